seg_scan_decoder: RTL and testbench

//   Receive-side decoder for the 4-digit multiplexed 7-segment display bus driven by the clock.

---
 rtl/seg_scan_decoder.sv | 198 +++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low 7-segment bus.
// Debounces each selected digit, decodes it to BCD and publishes complete HH:MM frames.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [3:0] sel_in,
    output logic [3:0] min_low,
    output logic [3:0] min_high,
    output logic [3:0] hr_low,
    output logic [3:0] hr_high,
    output logic       frame_valid,
    output logic       time_legal,
    output logic       err_pattern,
    output logic       err_timeout
);
    localparam int unsigned SW = $clog2(STABLE_CYCLES);
    localparam int unsigned TW = $clog2(FRAME_TIMEOUT);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_MAX   = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_D1   = 2'd1,
        S_D2   = 2'd2,
        S_D3   = 2'd3
    } state_t;

    logic [7:0]    r_seg_s1, r_seg_s2, r_seg_prev;
    logic [3:0]    r_sel_s1, r_sel_s2, r_sel_prev;
    logic [SW-1:0] r_stab_cnt;
    logic          r_accept;
    logic [7:0]    r_acc_seg;
    logic [3:0]    r_acc_sel;
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_sh0, r_sh1, r_sh2;
    logic          r_bad;
    logic [TW-1:0] r_to_cnt;

    logic       w_onehot, w_same;
    logic [3:0] w_code;
    logic       w_code_bad;
    logic [1:0] w_idx;
    logic       w_start, w_store, w_publish, w_legal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_seg_prev <= '1;
            r_sel_s1   <= '0;
            r_sel_s2   <= '0;
            r_sel_prev <= '0;
        end else begin
            r_seg_s1   <= seg_in;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_sel_s1   <= sel_in;
            r_sel_s2   <= r_sel_s1;
            r_sel_prev <= r_sel_s2;
        end
    end

    assign w_onehot = (r_sel_s2 != '0) && ((r_sel_s2 & (r_sel_s2 - 4'd1)) == '0);
    assign w_same   = ({r_sel_s2, r_seg_s2} == {r_sel_prev, r_seg_prev});

    // Accept fires only on the PRE->MAX step, so a saturated episode never re-accepts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stab_cnt <= '0;
            r_accept   <= 1'b0;
            r_acc_seg  <= '1;
            r_acc_sel  <= '0;
        end else begin
            r_accept <= 1'b0;
            if (!w_onehot || !w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
                if (r_stab_cnt == STAB_PRE) begin
                    r_accept  <= 1'b1;
                    r_acc_seg <= r_seg_s2;
                    r_acc_sel <= r_sel_s2;
                end
            end
        end
    end

    always_comb begin
        case (r_acc_seg)
            8'hC0:   w_code = 4'h0;
            8'hF9:   w_code = 4'h1;
            8'hA4:   w_code = 4'h2;
            8'hB0:   w_code = 4'h3;
            8'h99:   w_code = 4'h4;
            8'h92:   w_code = 4'h5;
            8'h82:   w_code = 4'h6;
            8'hF8:   w_code = 4'h7;
            8'h80:   w_code = 4'h8;
            8'h90:   w_code = 4'h9;
            8'h86:   w_code = 4'hE;
            default: w_code = 4'hF;
        endcase
    end

    assign w_code_bad = (w_code == 4'hE) || (w_code == 4'hF);

    always_comb begin
        case (r_acc_sel)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_SYNC;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_accept) begin
            if (w_idx == 2'd0) begin
                w_state_nxt = S_D1;
            end else begin
                case (r_state)
                    S_D1:    w_state_nxt = (w_idx == 2'd1) ? S_D2 : S_SYNC;
                    S_D2:    w_state_nxt = (w_idx == 2'd2) ? S_D3 : S_SYNC;
                    default: w_state_nxt = S_SYNC;
                endcase
            end
        end
    end

    always_comb begin
        w_start   = r_accept && (w_idx == 2'd0);
        w_store   = r_accept && (w_idx != 2'd0) && (w_idx == r_state);
        w_publish = w_store && (r_state == S_D3);
    end

    // Digit 3 is the accept being published, so it feeds the outputs directly.
    assign w_legal = !(r_bad || w_code_bad) && (r_sh0 <= 4'd9) && (r_sh1 <= 4'd5) &&
                     (r_sh2 <= 4'd9) && (w_code <= 4'd2) &&
                     !((w_code == 4'd2) && (r_sh2 > 4'd3));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            r_bad       <= 1'b0;
            min_low     <= '0;
            min_high    <= '0;
            hr_low      <= '0;
            hr_high     <= '0;
            frame_valid <= 1'b0;
            time_legal  <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (w_start) begin
                r_sh0 <= w_code;
                r_bad <= w_code_bad;
            end else if (w_publish) begin
                min_low     <= r_sh0;
                min_high    <= r_sh1;
                hr_low      <= r_sh2;
                hr_high     <= w_code;
                frame_valid <= 1'b1;
                err_pattern <= r_bad || w_code_bad;
                time_legal  <= w_legal;
            end else if (w_store) begin
                if (w_idx == 2'd1) r_sh1 <= w_code;
                else               r_sh2 <= w_code;
                r_bad <= r_bad || w_code_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt    <= '0;
            err_timeout <= 1'b0;
        end else if (frame_valid) begin
            r_to_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
            else                    err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: scan tasks push expected frames, a monitor pops
// and compares them on every frame_valid.
module tb_seg_scan_decoder;
    localparam int STABLE = 16;
    localparam int TO     = 3000;
    localparam int HOLD   = 40;

    typedef struct packed {
        logic [3:0] hh;
        logic [3:0] hl;
        logic [3:0] mh;
        logic [3:0] ml;
        logic       legal;
        logic       errp;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seg_in = 8'hFF;
    logic [3:0] sel_in = 4'h0;
    logic [3:0] min_low, min_high, hr_low, hr_high;
    logic       frame_valid, time_legal, err_pattern, err_timeout;

    frame_t     q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] SEG [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_scan_decoder #(.STABLE_CYCLES(STABLE), .FRAME_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
        .min_low(min_low), .min_high(min_high), .hr_low(hr_low), .hr_high(hr_high),
        .frame_valid(frame_valid), .time_legal(time_legal),
        .err_pattern(err_pattern), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        frame_t exp_f, act_f;
        if (rst === 1'b1 && frame_valid === 1'b1) begin
            n_vec++;
            act_f = {hr_high, hr_low, min_high, min_low, time_legal, err_pattern};
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_frame: got %h, expected no frame", act_f);
            end else begin
                exp_f = q.pop_front();
                if (act_f !== exp_f) begin
                    n_bad++;
                    $display("FAIL frame: got %h, expected %h", act_f, exp_f);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int cycles);
        sel_in = sel;
        seg_in = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        drive(4'h0, 8'hFF, cycles);
    endtask

    task automatic scan(input logic [7:0] s0, s1, s2, s3);
        drive(4'b0001, s0, HOLD);
        drive(4'b0010, s1, HOLD);
        drive(4'b0100, s2, HOLD);
        drive(4'b1000, s3, HOLD);
    endtask

    task automatic push(input logic [3:0] hh, hl, mh, ml, input logic legal, errp);
        frame_t f;
        f = {hh, hl, mh, ml, legal, errp};
        q.push_back(f);
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s: %0d frames still pending, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        logic [19:0] act;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        act = {hr_high, hr_low, min_high, min_low, frame_valid, time_legal, err_pattern, err_timeout};
        n_vec++;
        if (act !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 00000", act);
        end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        push(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        push(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        scan(SEG[4], SEG[3], SEG[2], SEG[1]);
        scan(SEG[4], SEG[3], SEG[2], SEG[1]);
        idle(10);
        check_drained("basic_1234");
    endtask

    task automatic test_legal_boundary();
        push(4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0);
        push(4'd2, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        scan(SEG[9], SEG[5], SEG[3], SEG[2]);
        scan(SEG[0], SEG[0], SEG[4], SEG[2]);
        idle(10);
        check_drained("legal_2359_2400");
    endtask

    task automatic test_bad_pattern();
        push(4'd1, 4'd2, 4'hE, 4'd4, 1'b0, 1'b1);
        push(4'd1, 4'd2, 4'hF, 4'd4, 1'b0, 1'b1);
        push(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        scan(SEG[4], 8'h86, SEG[2], SEG[1]);
        scan(SEG[4], 8'hFF, SEG[2], SEG[1]);
        scan(SEG[4], SEG[3], SEG[2], SEG[1]);
        idle(10);
        check_drained("bad_pattern");
    endtask

    task automatic test_unstable_timeout();
        logic [15:0] held;
        n_vec++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_initial: got %b, expected 0", err_timeout);
        end
        for (int k = 0; k < 164; k++) begin
            drive(4'(1 << (k % 4)), SEG[k % 10], STABLE - 2);
            drive(4'b0011, SEG[8], 3);
        end
        n_vec++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got %b, expected 0", err_timeout);
        end
        for (int k = 0; k < 20; k++) begin
            drive(4'(1 << (k % 4)), SEG[k % 10], STABLE - 2);
            drive(4'b0011, SEG[8], 3);
        end
        n_vec++;
        if (err_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_set: got %b, expected 1", err_timeout);
        end
        held = {hr_high, hr_low, min_high, min_low};
        n_vec++;
        if (held !== 16'h1234) begin
            n_bad++;
            $display("FAIL outputs_hold: got %h, expected 1234", held);
        end
        idle(10);
        check_drained("unstable_no_frame");
    endtask

    task automatic test_out_of_order();
        drive(4'b0001, SEG[4], HOLD);
        drive(4'b0100, SEG[2], HOLD);
        drive(4'b0010, SEG[3], HOLD);
        drive(4'b1000, SEG[1], HOLD);
        idle(10);
        check_drained("out_of_order_no_frame");
        push(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        scan(SEG[4], SEG[3], SEG[2], SEG[1]);
        idle(10);
        check_drained("in_order_after");
        n_vec++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_cleared: got %b, expected 0", err_timeout);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [19:0] act;
        drive(4'b0001, SEG[5], HOLD);
        drive(4'b0010, SEG[4], HOLD);
        drive(4'b0100, SEG[7], 5);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        act = {hr_high, hr_low, min_high, min_low, frame_valid, time_legal, err_pattern, err_timeout};
        n_vec++;
        if (act !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: got %h, expected 00000", act);
        end
        rst = 1'b1;
        drive(4'b0010, SEG[4], HOLD);
        drive(4'b0100, SEG[7], HOLD);
        drive(4'b1000, SEG[0], HOLD);
        idle(10);
        check_drained("reset_discards_partial");
        push(4'd0, 4'd7, 4'd4, 4'd5, 1'b1, 1'b0);
        scan(SEG[5], SEG[4], SEG[7], SEG[0]);
        idle(10);
        check_drained("after_reset_frame");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_legal_boundary();
        test_bad_pattern();
        test_unstable_timeout();
        test_out_of_order();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
